alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state updates on posedge.
  rst_n  in  1  asynchronous, active-low reset.
  start  in  1  request; sampled only in IDLE.
  op  in  4  operation: 0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 ANA, 5 XRA, 6 ORA, 7 CMP, 8 INR, 9 DCR; 10-15 illegal.
  cy_in  in  1  current carry flag.
  busy  out  1  high from FETCH through WB.
  done  out  1  one-cycle pulse on return to IDLE.
  illegal  out  1  one-cycle pulse on rejected op.
  select_op1, select_op2, select_neg, select_ncarry_1  out  1 each  ALU function select.
  select_shift_right, shift_right_in  out  1 each  tied 0.
  alu_cin_n  out  1  inverted carry into ALU bit 0.
  a_to_act, dbus_to_act, sel_0_fe, fe_0_to_act, write_dbus_to_alu_tmp  out  1 each  operand-latch controls.
  alu_to_a, sel_alu_a, alu_a_to_dbus  out  1 each  result routing.
  flag_we, flag_cy_we, flag_cy_clr  out  1 each  flag write strobes.
REQ-002 Clock port SHALL be named clk; reset port rst_n, asynchronous, active-low.

Function
REQ-003 FSM states SHALL be IDLE, FETCH, EXEC, WB; all outputs registered (Moore), so they are stable at the datapath's negedge.
REQ-004 IDLE->FETCH SHALL occur on posedge with start=1 and op<=9; op and cy_in SHALL be captured at that edge and held internally until WB completes.
REQ-005 start=1 in IDLE with op>=10 SHALL pulse illegal for one cycle and remain in IDLE.
REQ-006 start while busy SHALL be ignored (no queueing).
REQ-007 FETCH SHALL assert write_dbus_to_alu_tmp=1 for all ops; for ops 0-7, a_to_act=1, sel_0_fe=0; for INR, sel_0_fe=1, fe_0_to_act=0 (act=00h); for DCR, sel_0_fe=1, fe_0_to_act=1 (act=FEh).
REQ-008 dbus_to_act SHALL be 0 in every state.
REQ-009 The function select {select_op1, select_op2, select_neg, select_ncarry_1} SHALL be driven in FETCH, EXEC and WB as: ADD/ADC/INR/DCR 1000; SUB/SBB/CMP 1010; ANA 1100; XRA 1001; ORA 0001. It SHALL be 0000 in IDLE.
REQ-010 alu_cin_n SHALL be: ADD 1; ADC ~cy; SUB/CMP 0; SBB cy; INR/DCR 0; ANA/XRA/ORA 1 (cy = captured cy_in). It SHALL be 1 in IDLE.
REQ-011 The FETCH->EXEC and EXEC->WB transitions SHALL be unconditional; EXEC SHALL hold the select lines with no strobes asserted.
REQ-012 In WB, alu_to_a SHALL be 1 for ops 0-6 and 0 for CMP/INR/DCR.
REQ-013 In WB for INR/DCR, sel_alu_a=1 and alu_a_to_dbus=1; for all other ops both SHALL be 0.
REQ-014 In WB, flag_we SHALL be 1 for all legal ops.
REQ-015 In WB, flag_cy_we SHALL be 1 for ops 0-7 and 0 for INR/DCR.
REQ-016 In WB, flag_cy_clr SHALL be 1 for ANA/XRA/ORA only.
REQ-017 WB->IDLE SHALL be unconditional, with done=1 in the first IDLE cycle.
REQ-018 Latency: start sampled at edge N -> FETCH N+1, EXEC N+2, WB N+3, done N+4.
REQ-019 Back-to-back: start held high with done=1 SHALL be accepted on that same edge (IDLE->FETCH).
REQ-020 All strobes not listed for a state SHALL be 0 in that state.

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE and drive all outputs to 0 except alu_cin_n=1; this applies in any state, including mid-operation.
REQ-022 Reset SHALL clear captured op/cy; no done pulse SHALL follow reset.
REQ-023 The first start after rst_n rises SHALL be honoured on the first posedge.

Verification
REQ-024 ADD: start, op=0 -> FETCH a_to_act=1, tmp load; WB alu_to_a=1, flag_we=1, flag_cy_we=1; done at N+4; select=1000, alu_cin_n=1.
REQ-025 SBB with cy_in=1 -> select=1010, alu_cin_n=1; cy_in toggling after start does not change alu_cin_n.
REQ-026 DCR: op=9 -> FETCH sel_0_fe=1, fe_0_to_act=1; WB alu_a_to_dbus=1, sel_alu_a=1, alu_to_a=0, flag_cy_we=0.
REQ-027 CMP: op=7 -> WB alu_to_a=0, flag_we=1, flag_cy_we=1; ORA: op=6 -> flag_cy_clr=1 in WB.
REQ-028 Illegal and busy: op=12 -> illegal pulse, busy stays 0; start during EXEC -> ignored, single done.
REQ-029 Reset mid-op: rst_n low during EXEC -> outputs 0 (alu_cin_n=1) without waiting for a clock edge; no done pulse; a new start after release completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// Four-state control sequencer for an 8080-style ALU: fetches operands, executes, writes back.
// Every control output is a flop loaded with the value for the state being entered.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] op,
    input  logic       cy_in,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic       select_op1,
    output logic       select_op2,
    output logic       select_neg,
    output logic       select_ncarry_1,
    output logic       select_shift_right,
    output logic       shift_right_in,
    output logic       alu_cin_n,
    output logic       a_to_act,
    output logic       dbus_to_act,
    output logic       sel_0_fe,
    output logic       fe_0_to_act,
    output logic       write_dbus_to_alu_tmp,
    output logic       alu_to_a,
    output logic       sel_alu_a,
    output logic       alu_a_to_dbus,
    output logic       flag_we,
    output logic       flag_cy_we,
    output logic       flag_cy_clr
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_ANA = 4'd4;
    localparam logic [3:0] OP_XRA = 4'd5;
    localparam logic [3:0] OP_ORA = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_INR = 4'd8;
    localparam logic [3:0] OP_DCR = 4'd9;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic illegal;
        logic select_op1;
        logic select_op2;
        logic select_neg;
        logic select_ncarry_1;
        logic alu_cin_n;
        logic a_to_act;
        logic sel_0_fe;
        logic fe_0_to_act;
        logic write_dbus_to_alu_tmp;
        logic alu_to_a;
        logic sel_alu_a;
        logic alu_a_to_dbus;
        logic flag_we;
        logic flag_cy_we;
        logic flag_cy_clr;
    } ctrl_t;

    state_t     state_reg, state_next;
    logic [3:0] op_reg, op_next;
    logic       cy_reg, cy_next;
    ctrl_t      ctrl_reg, ctrl_next;
    logic       op_legal;
    logic       accept;

    assign op_legal = (op < 4'd10);
    assign accept   = (state_reg == IDLE) && start && op_legal;

    // State register; captured operands and control flops share the async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            op_reg             <= 4'd0;
            cy_reg             <= 1'b0;
            ctrl_reg           <= '0;
            ctrl_reg.alu_cin_n <= 1'b1;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            cy_reg    <= cy_next;
            ctrl_reg  <= ctrl_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        cy_next    = cy_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = FETCH;
                    op_next    = op;
                    cy_next    = cy_in;
                end
            end
            FETCH:   state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode for the state being entered, so the flops present it for the whole cycle.
    always_comb begin
        ctrl_next           = '0;
        ctrl_next.alu_cin_n = 1'b1;
        ctrl_next.busy      = (state_next != IDLE);
        ctrl_next.done      = (state_reg == WB);
        ctrl_next.illegal   = (state_reg == IDLE) && start && !op_legal;

        if (state_next != IDLE) begin
            case (op_next)
                OP_SUB, OP_SBB, OP_CMP: {ctrl_next.select_op1, ctrl_next.select_op2,
                                         ctrl_next.select_neg, ctrl_next.select_ncarry_1} = 4'b1010;
                OP_ANA:                 {ctrl_next.select_op1, ctrl_next.select_op2,
                                         ctrl_next.select_neg, ctrl_next.select_ncarry_1} = 4'b1100;
                OP_XRA:                 {ctrl_next.select_op1, ctrl_next.select_op2,
                                         ctrl_next.select_neg, ctrl_next.select_ncarry_1} = 4'b1001;
                OP_ORA:                 {ctrl_next.select_op1, ctrl_next.select_op2,
                                         ctrl_next.select_neg, ctrl_next.select_ncarry_1} = 4'b0001;
                default:                {ctrl_next.select_op1, ctrl_next.select_op2,
                                         ctrl_next.select_neg, ctrl_next.select_ncarry_1} = 4'b1000;
            endcase
            case (op_next)
                OP_ADC:                         ctrl_next.alu_cin_n = ~cy_next;
                OP_SBB:                         ctrl_next.alu_cin_n = cy_next;
                OP_SUB, OP_CMP, OP_INR, OP_DCR: ctrl_next.alu_cin_n = 1'b0;
                default:                        ctrl_next.alu_cin_n = 1'b1;
            endcase
        end

        case (state_next)
            FETCH: begin
                ctrl_next.write_dbus_to_alu_tmp = 1'b1;
                if (op_next <= OP_CMP) begin
                    ctrl_next.a_to_act = 1'b1;
                end else begin
                    // INR adds 00h+1, DCR adds FEh+1 (i.e. subtracts one).
                    ctrl_next.sel_0_fe    = 1'b1;
                    ctrl_next.fe_0_to_act = (op_next == OP_DCR);
                end
            end
            WB: begin
                ctrl_next.alu_to_a      = (op_next <= OP_ORA);
                ctrl_next.sel_alu_a     = (op_next >= OP_INR);
                ctrl_next.alu_a_to_dbus = (op_next >= OP_INR);
                ctrl_next.flag_we       = 1'b1;
                ctrl_next.flag_cy_we    = (op_next <= OP_CMP);
                ctrl_next.flag_cy_clr   = (op_next == OP_ANA) || (op_next == OP_XRA) ||
                                          (op_next == OP_ORA);
            end
            default: ;
        endcase
    end

    assign busy                  = ctrl_reg.busy;
    assign done                  = ctrl_reg.done;
    assign illegal               = ctrl_reg.illegal;
    assign select_op1            = ctrl_reg.select_op1;
    assign select_op2            = ctrl_reg.select_op2;
    assign select_neg            = ctrl_reg.select_neg;
    assign select_ncarry_1       = ctrl_reg.select_ncarry_1;
    assign select_shift_right    = 1'b0;
    assign shift_right_in        = 1'b0;
    assign alu_cin_n             = ctrl_reg.alu_cin_n;
    assign a_to_act              = ctrl_reg.a_to_act;
    assign dbus_to_act           = 1'b0;
    assign sel_0_fe              = ctrl_reg.sel_0_fe;
    assign fe_0_to_act           = ctrl_reg.fe_0_to_act;
    assign write_dbus_to_alu_tmp = ctrl_reg.write_dbus_to_alu_tmp;
    assign alu_to_a              = ctrl_reg.alu_to_a;
    assign sel_alu_a             = ctrl_reg.sel_alu_a;
    assign alu_a_to_dbus         = ctrl_reg.alu_a_to_dbus;
    assign flag_we               = ctrl_reg.flag_we;
    assign flag_cy_we            = ctrl_reg.flag_cy_we;
    assign flag_cy_clr           = ctrl_reg.flag_cy_clr;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus random traffic, every cycle compared
// against a phase-counter model that derives the ALU controls from the arithmetic of each op.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] op;
    logic       cy_in;
    logic busy, done, illegal, select_op1, select_op2, select_neg, select_ncarry_1;
    logic select_shift_right, shift_right_in, alu_cin_n, a_to_act, dbus_to_act;
    logic sel_0_fe, fe_0_to_act, write_dbus_to_alu_tmp, alu_to_a, sel_alu_a;
    logic alu_a_to_dbus, flag_we, flag_cy_we, flag_cy_clr;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cy_in(cy_in),
        .busy(busy), .done(done), .illegal(illegal),
        .select_op1(select_op1), .select_op2(select_op2), .select_neg(select_neg),
        .select_ncarry_1(select_ncarry_1), .select_shift_right(select_shift_right),
        .shift_right_in(shift_right_in), .alu_cin_n(alu_cin_n), .a_to_act(a_to_act),
        .dbus_to_act(dbus_to_act), .sel_0_fe(sel_0_fe), .fe_0_to_act(fe_0_to_act),
        .write_dbus_to_alu_tmp(write_dbus_to_alu_tmp), .alu_to_a(alu_to_a),
        .sel_alu_a(sel_alu_a), .alu_a_to_dbus(alu_a_to_dbus), .flag_we(flag_we),
        .flag_cy_we(flag_cy_we), .flag_cy_clr(flag_cy_clr)
    );

    logic [20:0] obs;
    assign obs = {busy, done, illegal, select_op1, select_op2, select_neg, select_ncarry_1,
                  select_shift_right, shift_right_in, alu_cin_n, a_to_act, dbus_to_act,
                  sel_0_fe, fe_0_to_act, write_dbus_to_alu_tmp, alu_to_a, sel_alu_a,
                  alu_a_to_dbus, flag_we, flag_cy_we, flag_cy_clr};

    localparam logic [20:0] RESET_VEC = 21'h000800;

    int checks = 0;
    int passes = 0;

    // Model: phase 0 idle, 1 fetch, 2 exec, 3 write-back.
    int         m_phase = 0;
    logic [3:0] m_op = 4'd0;
    logic       m_cy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_ill = 1'b0;

    function automatic logic [20:0] model_vec(input int phase, input logic [3:0] o,
                                              input logic c, input logic d, input logic il);
        logic bsy, s1, s2, sn, snc, cin, a_act, s0, fe, tmp, to_a, sela, adb, fwe, fcy, fclr;
        {bsy, s1, s2, sn, snc, cin, a_act, s0, fe, tmp} = '0;
        {to_a, sela, adb, fwe, fcy, fclr} = '0;
        if (phase != 0) begin
            bsy = 1'b1;
            case (o)
                4'd2, 4'd3, 4'd7: {s1, s2, sn, snc} = 4'b1010;
                4'd4:             {s1, s2, sn, snc} = 4'b1100;
                4'd5:             {s1, s2, sn, snc} = 4'b1001;
                4'd6:             {s1, s2, sn, snc} = 4'b0001;
                default:          {s1, s2, sn, snc} = 4'b1000;
            endcase
            // True carry into bit 0: subtraction is A + ~B + 1, borrow subtracts it back out.
            case (o)
                4'd1:             cin = c;
                4'd2, 4'd7:       cin = 1'b1;
                4'd3:             cin = ~c;
                4'd8, 4'd9:       cin = 1'b1;
                default:          cin = 1'b0;
            endcase
        end
        if (phase == 1) begin
            tmp = 1'b1;
            if (o < 4'd8) a_act = 1'b1;
            else begin
                s0 = 1'b1;
                fe = (o == 4'd9);
            end
        end
        if (phase == 3) begin
            to_a = (o <= 4'd6);
            sela = (o >= 4'd8);
            adb  = (o >= 4'd8);
            fwe  = 1'b1;
            fcy  = (o <= 4'd7);
            fclr = (o == 4'd4) || (o == 4'd5) || (o == 4'd6);
        end
        return {bsy, d, il, s1, s2, sn, snc, 1'b0, 1'b0, ~cin, a_act, 1'b0, s0, fe, tmp,
                to_a, sela, adb, fwe, fcy, fclr};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_op    = 4'd0;
        m_cy    = 1'b0;
        m_done  = 1'b0;
        m_ill   = 1'b0;
    endtask

    // Drive one cycle of inputs, advance through a posedge, and step the model.
    task automatic step(input logic s, input logic [3:0] o, input logic c);
        start = s;
        op    = o;
        cy_in = c;
        @(posedge clk);
        m_done = (m_phase == 3);
        m_ill  = 1'b0;
        if (m_phase == 0) begin
            if (s && o < 4'd10) begin
                m_phase = 1;
                m_op    = o;
                m_cy    = c;
            end else begin
                m_ill = s;
            end
        end else begin
            m_phase = (m_phase == 3) ? 0 : m_phase + 1;
        end
        #1;
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic c,
                          input logic wiggle_cy);
        logic [20:0] exp_v;
        step(1'b1, o, c);
        for (int i = 0; i < 4; i++) begin
            exp_v = model_vec(m_phase, m_op, m_cy, m_done, m_ill);
            checks++;
            if (obs !== exp_v)
                $display("FAIL %s cycle%0d got=%b exp=%b", name, i + 1, obs, exp_v);
            else
                passes++;
            if (i < 3) step(1'b0, 4'd0, wiggle_cy ? 1'($urandom_range(0, 1)) : c);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op    = 4'd0;
        cy_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== RESET_VEC) $display("FAIL reset got=%b exp=%b", obs, RESET_VEC);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        step(1'b1, 4'd0, 1'b1);
        checks++;
        if ({a_to_act, write_dbus_to_alu_tmp, sel_0_fe, select_op1, select_op2, select_neg,
             select_ncarry_1, alu_cin_n} !== 8'b1101_0001)
            $display("FAIL add_fetch got=%b exp=11010001", {a_to_act, write_dbus_to_alu_tmp,
                     sel_0_fe, select_op1, select_op2, select_neg, select_ncarry_1, alu_cin_n});
        else passes++;
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        checks++;
        if ({alu_to_a, flag_we, flag_cy_we, flag_cy_clr} !== 4'b1110)
            $display("FAIL add_wb got=%b exp=1110", {alu_to_a, flag_we, flag_cy_we, flag_cy_clr});
        else passes++;
        step(1'b0, 4'd0, 1'b0);
        checks++;
        if ({done, busy} !== 2'b10) $display("FAIL add_done got=%b exp=10", {done, busy});
        else passes++;
        step(1'b0, 4'd0, 1'b0);
        checks++;
        if (done !== 1'b0) $display("FAIL add_done_pulse got=%b exp=0", done);
        else passes++;
    endtask

    task automatic test_sbb();
        run_op("sbb_cy1", 4'd3, 1'b1, 1'b1);
        run_op("sbb_cy0", 4'd3, 1'b0, 1'b1);
        run_op("adc_cy1", 4'd1, 1'b1, 1'b1);
    endtask

    task automatic test_inr_dcr();
        run_op("dcr", 4'd9, 1'b0, 1'b0);
        run_op("inr", 4'd8, 1'b1, 1'b0);
    endtask

    task automatic test_cmp_logic();
        run_op("cmp", 4'd7, 1'b1, 1'b0);
        run_op("ora", 4'd6, 1'b1, 1'b0);
        run_op("ana", 4'd4, 1'b0, 1'b0);
        run_op("xra", 4'd5, 1'b1, 1'b0);
        run_op("sub", 4'd2, 1'b1, 1'b0);
    endtask

    task automatic test_illegal_busy();
        int dones;
        step(1'b1, 4'd12, 1'b0);
        checks++;
        if ({illegal, busy} !== 2'b10) $display("FAIL illegal_pulse got=%b exp=10", {illegal, busy});
        else passes++;
        step(1'b0, 4'd0, 1'b0);
        checks++;
        if ({illegal, busy} !== 2'b00) $display("FAIL illegal_clear got=%b exp=00", {illegal, busy});
        else passes++;
        dones = 0;
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd6, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        if (done === 1'b1) dones++;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'd0, 1'b0);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 1) $display("FAIL busy_ignore dones=%0d exp=1", dones);
        else passes++;
    endtask

    task automatic test_reset_mid_op();
        logic [20:0] exp_v;
        step(1'b1, 4'd2, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        checks++;
        if (busy !== 1'b1) $display("FAIL midop_busy got=%b exp=1", busy);
        else passes++;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== RESET_VEC) $display("FAIL midop_async got=%b exp=%b", obs, RESET_VEC);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== RESET_VEC) $display("FAIL midop_hold got=%b exp=%b", obs, RESET_VEC);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'd5, 1'b0);
        exp_v = model_vec(m_phase, m_op, m_cy, m_done, m_ill);
        checks++;
        if (obs !== exp_v) $display("FAIL after_reset_first got=%b exp=%b", obs, exp_v);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'd0, 1'b0);
            exp_v = model_vec(m_phase, m_op, m_cy, m_done, m_ill);
            checks++;
            if (obs !== exp_v) $display("FAIL after_reset c%0d got=%b exp=%b", i, obs, exp_v);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] exp_v;
        step(1'b1, 4'd1, 1'b1);
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd9, 1'b0);
        checks++;
        if ({done, busy} !== 2'b10) $display("FAIL b2b_done got=%b exp=10", {done, busy});
        else passes++;
        step(1'b1, 4'd9, 1'b1);
        exp_v = model_vec(m_phase, m_op, m_cy, m_done, m_ill);
        checks++;
        if (obs !== exp_v || busy !== 1'b1 || fe_0_to_act !== 1'b1)
            $display("FAIL b2b_accept got=%b exp=%b", obs, exp_v);
        else passes++;
        repeat (4) step(1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_random();
        logic [20:0] exp_v;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            exp_v = model_vec(m_phase, m_op, m_cy, m_done, m_ill);
            checks++;
            if (obs !== exp_v) $display("FAIL random c%0d got=%b exp=%b", i, obs, exp_v);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sbb();
        test_inr_dcr();
        test_cmp_logic();
        test_illegal_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
